// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic generator: FSM states and the
// 16-bit Galois LFSR step used by both pseudo-random sources.
package noc_tg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tg_state_e;

  // Galois feedback mask for a right-shifting 16-bit maximal-length LFSR.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with a load-on-reset seed and a step enable.
// An all-zero seed would lock the register, so it is replaced by 1.
module lfsr16
  import noc_tg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  input  logic        enable,
  output logic [15:0] value
);

  logic [15:0] seed_eff;
  logic [15:0] value_q;

  assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;

  // Load the seed on reset, otherwise step once per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= seed_eff;
    end else if (enable) begin
      value_q <= lfsr16_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/axis_tg_lfsr.sv
// AXI-Stream single-flit traffic generator for a NoC endpoint.
// Injection is Bernoulli (draw r < load), destinations are uniform from a
// second LFSR. Each flit carries {timestamp, per-destination sequence no.}.
module axis_tg_lfsr
  import noc_tg_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'h0001,
  parameter int          COUNT_WIDTH  = 32,
  parameter int          TID          = 0,
  parameter int          TDATA_WIDTH  = 64,
  parameter int          TDEST_WIDTH  = 4,
  parameter int          TID_WIDTH    = 4,
  parameter int          NUM_ROUTERS  = 16,
  parameter int          DISABLE_SELF = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [15:0]                             load,
  input  logic [COUNT_WIDTH-1:0]                  num_packets,
  input  logic                                    start,
  input  logic [TDATA_WIDTH/2-1:0]                ticks,
  output logic                                    done,
  output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] sent_packets,
  output logic [COUNT_WIDTH-1:0]                  total_sent_packets,
  output logic                                    axis_out_tvalid,
  input  logic                                    axis_out_tready,
  output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
  output logic                                    axis_out_tlast,
  output logic [TID_WIDTH-1:0]                    axis_out_tid,
  output logic [TDEST_WIDTH-1:0]                  axis_out_tdest
);

  localparam int          SEQ_W    = TDATA_WIDTH / 2;
  localparam int          IDX_W    = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1;
  localparam logic [15:0] SEED_INJ = SEED;
  localparam logic [15:0] SEED_DST = SEED ^ 16'hACE1;
  localparam logic [7:0]  SELF_ALT = 8'((TID + 1) % NUM_ROUTERS);

  tg_state_e                        state_q;
  logic                             done_q;
  logic                             tvalid_q;
  logic [TDATA_WIDTH-1:0]           tdata_q;
  logic [TDEST_WIDTH-1:0]           tdest_q;
  logic [COUNT_WIDTH-1:0]           issued_q;
  logic [COUNT_WIDTH-1:0]           target_q;
  logic [COUNT_WIDTH-1:0]           total_q;
  logic [NUM_ROUTERS-1:0][SEQ_W-1:0] seq_w;

  logic [15:0]      r_val;
  logic [15:0]      d_val;
  logic             run_st;
  logic             slot_free;
  logic             hs;
  logic             gen;
  logic             clr_cnt;
  logic [15:0]      dest_prod;
  logic [7:0]       dest_raw;
  logic [7:0]       dest_sel;
  logic [IDX_W-1:0] dest_idx;
  logic             unused_bits;

  assign run_st    = (state_q == RUN);
  assign hs        = tvalid_q & axis_out_tready;
  // The slot can take a new flit if empty or being emptied this cycle.
  assign slot_free = ~tvalid_q | axis_out_tready;
  assign gen       = run_st & slot_free & (issued_q < target_q) & (r_val < load);
  assign clr_cnt   = (state_q == IDLE) & start;

  // Scale the 8-bit draw onto [0, NUM_ROUTERS) and steer around ourselves.
  assign dest_prod = {8'h00, d_val[7:0]} * 16'(NUM_ROUTERS);
  assign dest_raw  = dest_prod[15:8];
  assign dest_sel  = ((DISABLE_SELF != 0) && (dest_raw == 8'(TID))) ? SELF_ALT : dest_raw;
  assign dest_idx  = IDX_W'(dest_sel);

  assign unused_bits = ^{dest_prod[7:0], d_val[15:8]};

  lfsr16 u_inj_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed   (SEED_INJ),
    .enable (run_st),
    .value  (r_val)
  );

  lfsr16 u_dst_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .seed   (SEED_DST),
    .enable (gen),
    .value  (d_val)
  );

  // Output slot: load on generation, clear on handshake, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tdest_q  <= '0;
    end else if (gen) begin
      tvalid_q <= 1'b1;
      tdata_q  <= {ticks, seq_w[dest_idx]};
      tdest_q  <= TDEST_WIDTH'(dest_sel);
    end else if (hs) begin
      tvalid_q <= 1'b0;
    end
  end

  // Run bookkeeping: issued flits, latched run length and total handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q <= '0;
      target_q <= '0;
      total_q  <= '0;
    end else if (clr_cnt) begin
      issued_q <= '0;
      target_q <= num_packets;
      total_q  <= '0;
    end else begin
      if (gen) issued_q <= issued_q + 1'b1;
      if (hs)  total_q  <= total_q + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROUTERS; gi++) begin : g_dst
      logic [COUNT_WIDTH-1:0] sent_cnt_q;
      logic [SEQ_W-1:0]       seq_cnt_q;

      // Per-destination handshake count and next sequence number.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sent_cnt_q <= '0;
          seq_cnt_q  <= '0;
        end else if (clr_cnt) begin
          sent_cnt_q <= '0;
          seq_cnt_q  <= '0;
        end else begin
          if (hs && (tdest_q == TDEST_WIDTH'(gi)))
            sent_cnt_q <= sent_cnt_q + 1'b1;
          if (gen && (dest_idx == IDX_W'(gi)))
            seq_cnt_q <= seq_cnt_q + 1'b1;
        end
      end

      assign sent_packets[gi] = sent_cnt_q;
      assign seq_w[gi]        = seq_cnt_q;
    end
  endgenerate

  // Run control; done is registered so it rises with the final handshake edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_packets != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issued_q == target_q) begin
            if (slot_free) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done               = done_q;
  assign total_sent_packets = total_q;
  assign axis_out_tvalid    = tvalid_q;
  assign axis_out_tdata     = tdata_q;
  assign axis_out_tdest     = tdest_q;
  assign axis_out_tlast     = 1'b1;
  assign axis_out_tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg_lfsr.sv
// Directed bench for axis_tg_lfsr (TID=3, self-traffic disabled, 16 routers).
// Destination sequences below are worked out by hand from the seeds.
module tb_axis_tg_lfsr;

  localparam int CW  = 32;
  localparam int TDW = 64;
  localparam int TW  = 32;
  localparam int NR  = 16;
  localparam int DW  = 4;
  localparam int IW  = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   tready;
  logic [15:0]            load;
  logic [CW-1:0]          num_packets;
  logic [TW-1:0]          ticks = '0;
  logic                   done;
  logic [NR-1:0][CW-1:0]  sent_packets;
  logic [CW-1:0]          total;
  logic                   tvalid;
  logic                   tlast;
  logic [TDW-1:0]         tdata;
  logic [IW-1:0]          tid;
  logic [DW-1:0]          tdest;

  int n_cmp = 0;
  int n_bad = 0;

  // First ten destinations from dest seed 16'hACE0 (dest 3 remapped to 4).
  int exp_dest [10] = '{14, 7, 4, 9, 12, 6, 11, 5, 10, 13};

  always #5 clk = ~clk;
  always @(posedge clk) ticks <= ticks + 1'b1;

  axis_tg_lfsr #(
    .SEED(16'h0001), .COUNT_WIDTH(CW), .TID(3), .TDATA_WIDTH(TDW),
    .TDEST_WIDTH(DW), .TID_WIDTH(IW), .NUM_ROUTERS(NR), .DISABLE_SELF(1)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (load),
    .num_packets        (num_packets),
    .start              (start),
    .ticks              (ticks),
    .done               (done),
    .sent_packets       (sent_packets),
    .total_sent_packets (total),
    .axis_out_tvalid    (tvalid),
    .axis_out_tready    (tready),
    .axis_out_tdata     (tdata),
    .axis_out_tlast     (tlast),
    .axis_out_tid       (tid),
    .axis_out_tdest     (tdest)
  );

  function automatic longint sum_sent();
    longint s = 0;
    for (int i = 0; i < NR; i++) s += sent_packets[i];
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tready = 1'b0; load = 16'h0; num_packets = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; tready = 1'b1; load = 16'hFFFF; num_packets = 5;
    repeat (2) @(negedge clk);
    n_cmp++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b want 0", tvalid); end
    n_cmp++; if (tdata !== '0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    n_cmp++; if (tdest !== '0) begin n_bad++; $display("FAIL reset_tdest: got %0d want 0", tdest); end
    n_cmp++; if (tid !== 4'd3) begin n_bad++; $display("FAIL reset_tid: got %0d want 3", tid); end
    n_cmp++; if (tlast !== 1'b1) begin n_bad++; $display("FAIL reset_tlast: got %0b want 1", tlast); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (total !== '0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", total); end
    n_cmp++; if (sum_sent() != 0) begin n_bad++; $display("FAIL reset_sent: got %0d want 0", sum_sent()); end
  endtask

  task automatic test_full_load();
    int hs = 0;
    do_reset();
    load = 16'hFFFF; num_packets = 8; tready = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 12 && hs < 8; cyc++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        $display("full_load flit %0d: tdest=%0d seq=%0d ts=%0d", hs, tdest, tdata[31:0], tdata[63:32]);
        n_cmp++; if (tdest !== 4'(exp_dest[hs])) begin n_bad++; $display("FAIL full_dest[%0d]: got %0d want %0d", hs, tdest, exp_dest[hs]); end
        n_cmp++; if (tdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL full_seq[%0d]: got %0d want 0", hs, tdata[31:0]); end
        n_cmp++; if (tdata[63:32] !== ticks - 1'b1) begin n_bad++; $display("FAIL full_ts[%0d]: got %0d want %0d", hs, tdata[63:32], ticks - 1'b1); end
        if (hs == 7) begin
          n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL full_done_early: got %0b want 0", done); end
        end
        hs++;
      end
    end
    n_cmp++; if (hs != 8) begin n_bad++; $display("FAIL full_count: got %0d handshakes want 8 within budget", hs); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %0b want 1", done); end
    n_cmp++; if (total !== 32'd8) begin n_bad++; $display("FAIL full_total: got %0d want 8", total); end
    n_cmp++; if (sum_sent() != 8) begin n_bad++; $display("FAIL full_sum: got %0d want 8", sum_sent()); end
    n_cmp++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL full_tvalid_after: got %0b want 0", tvalid); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (sent_packets[exp_dest[i]] !== 32'd1) begin n_bad++; $display("FAIL full_sent[%0d]: got %0d want 1", exp_dest[i], sent_packets[exp_dest[i]]); end
    end
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL full_done_drop: got %0b want 0", done); end
    n_cmp++; if (total !== 32'd8) begin n_bad++; $display("FAIL full_total_kept: got %0d want 8", total); end
  endtask

  task automatic test_empty_run();
    int vseen = 0;
    load = 16'hFFFF; num_packets = 0; tready = 1'b1; start = 1'b1;
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL empty_done: got %0b want 1", done); end
    n_cmp++; if (total !== '0) begin n_bad++; $display("FAIL empty_total: got %0d want 0", total); end
    n_cmp++; if (sum_sent() != 0) begin n_bad++; $display("FAIL empty_sent: got %0d want 0", sum_sent()); end
    repeat (5) begin
      @(negedge clk);
      if (tvalid) vseen++;
    end
    n_cmp++; if (vseen != 0) begin n_bad++; $display("FAIL empty_tvalid: got %0d valid cycles want 0", vseen); end
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL empty_done_drop: got %0b want 0", done); end
  endtask

  task automatic test_zero_load();
    int vseen = 0;
    int dseen = 0;
    do_reset();
    load = 16'h0000; num_packets = 100; tready = 1'b1; start = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (tvalid) vseen++;
      if (done) dseen++;
    end
    n_cmp++; if (vseen != 0) begin n_bad++; $display("FAIL zero_tvalid: got %0d valid cycles want 0", vseen); end
    n_cmp++; if (dseen != 0) begin n_bad++; $display("FAIL zero_done: got %0d done cycles want 0", dseen); end
  endtask

  task automatic test_backpressure();
    logic [TDW-1:0] d0;
    logic [DW-1:0]  dest0;
    bit             found = 0;
    bit             fin = 0;
    do_reset();
    load = 16'hFFFF; num_packets = 10; tready = 1'b0; start = 1'b1;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      if (tvalid) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL bp_first_valid: got none want tvalid within 10 cycles"); end
    d0 = tdata; dest0 = tdest;
    n_cmp++; if (dest0 !== 4'd14) begin n_bad++; $display("FAIL bp_dest0: got %0d want 14", dest0); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tvalid !== 1'b1 || tdata !== d0 || tdest !== dest0 || tid !== 4'd3 || total !== '0 || sum_sent() != 0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v=%0b data=%h dest=%0d tid=%0d total=%0d want v=1 data=%h dest=%0d tid=3 total=0",
                 i, tvalid, tdata, tdest, tid, total, d0, dest0);
      end
    end
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    n_cmp++; if (total !== 32'd1) begin n_bad++; $display("FAIL bp_release_total: got %0d want 1", total); end
    n_cmp++; if (sent_packets[14] !== 32'd1) begin n_bad++; $display("FAIL bp_release_sent14: got %0d want 1", sent_packets[14]); end
    n_cmp++; if (tvalid !== 1'b1 || tdest !== 4'd7) begin n_bad++; $display("FAIL bp_next_flit: got v=%0b dest=%0d want v=1 dest=7", tvalid, tdest); end
    @(negedge clk);
    n_cmp++; if (total !== 32'd1) begin n_bad++; $display("FAIL bp_single_inc: got %0d want 1", total); end
    tready = 1'b1;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      @(negedge clk);
      if (done) fin = 1;
    end
    n_cmp++; if (!fin || total !== 32'd10) begin n_bad++; $display("FAIL bp_drain: got done=%0b total=%0d want done=1 total=10", fin, total); end
    start = 1'b0;
  endtask

  task automatic test_self_traffic();
    int exp_seq [NR];
    int self_hits = 0;
    int seq_err = 0;
    int hs = 0;
    bit fin = 0;
    for (int i = 0; i < NR; i++) exp_seq[i] = 0;
    do_reset();
    load = 16'hFFFF; num_packets = 4096; tready = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      if (tvalid) begin
        if (tdest == 4'd3) self_hits++;
        if (tdata[31:0] !== 32'(exp_seq[tdest])) seq_err++;
        exp_seq[tdest]++;
        hs++;
      end
      if (done) fin = 1;
    end
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL self_done: got 0 want done within 6000 cycles"); end
    n_cmp++; if (hs != 4096) begin n_bad++; $display("FAIL self_count: got %0d want 4096", hs); end
    n_cmp++; if (self_hits != 0) begin n_bad++; $display("FAIL self_hits: got %0d flits to 3 want 0", self_hits); end
    n_cmp++; if (seq_err != 0) begin n_bad++; $display("FAIL self_seq: got %0d out-of-order seq want 0", seq_err); end
    n_cmp++; if (total !== 32'd4096) begin n_bad++; $display("FAIL self_total: got %0d want 4096", total); end
    n_cmp++; if (sent_packets[3] !== '0) begin n_bad++; $display("FAIL self_sent3: got %0d want 0", sent_packets[3]); end
    for (int i = 0; i < NR; i++) begin
      n_cmp++; if (sent_packets[i] !== 32'(exp_seq[i])) begin n_bad++; $display("FAIL self_sent[%0d]: got %0d want %0d", i, sent_packets[i], exp_seq[i]); end
      if (i != 3) begin
        n_cmp++; if (sent_packets[i] < 150) begin n_bad++; $display("FAIL self_min[%0d]: got %0d want >=150", i, sent_packets[i]); end
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] run1_dest [10];
    logic [31:0]   run1_seq  [10];
    int hs = 0;
    do_reset();
    load = 16'hFFFF; num_packets = 100; tready = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 20 && hs < 10; cyc++) begin
      @(negedge clk);
      if (tvalid) begin
        run1_dest[hs] = tdest; run1_seq[hs] = tdata[31:0];
        $display("mid_run first flit %0d: tdest=%0d seq=%0d", hs, tdest, tdata[31:0]);
        n_cmp++; if (tdest !== 4'(exp_dest[hs]) || tdata[31:0] !== 32'd0) begin n_bad++; $display("FAIL mid_first[%0d]: got dest=%0d seq=%0d want dest=%0d seq=0", hs, tdest, tdata[31:0], exp_dest[hs]); end
        hs++;
      end
    end
    n_cmp++; if (hs != 10) begin n_bad++; $display("FAIL mid_count1: got %0d want 10", hs); end
    @(negedge clk);
    n_cmp++; if (total !== 32'd10 || tvalid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_reset: got total=%0d v=%0b want total=10 v=1", total, tvalid); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_tvalid: got %0b want 0", tvalid); end
    n_cmp++; if (total !== '0 || sum_sent() != 0) begin n_bad++; $display("FAIL mid_counters: got total=%0d sum=%0d want 0", total, sum_sent()); end
    rst_n = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 20 && hs < 10; cyc++) begin
      @(negedge clk);
      if (tvalid) begin
        $display("mid_run rerun flit %0d: tdest=%0d seq=%0d", hs, tdest, tdata[31:0]);
        n_cmp++; if (tdest !== run1_dest[hs] || tdata[31:0] !== run1_seq[hs]) begin n_bad++; $display("FAIL mid_rerun[%0d]: got dest=%0d seq=%0d want dest=%0d seq=%0d", hs, tdest, tdata[31:0], run1_dest[hs], run1_seq[hs]); end
        hs++;
      end
    end
    n_cmp++; if (hs != 10) begin n_bad++; $display("FAIL mid_count2: got %0d want 10", hs); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_empty_run();
    test_zero_load();
    test_backpressure();
    test_self_traffic();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_tg_lfsr.md
# axis_tg_lfsr

Synthesizable AXI-Stream traffic generator that drives one NoC input port (`axis_in_*` of a torus/mesh router endpoint) with single-flit packets at a programmable Bernoulli injection rate and uniform-random destinations. It is the on-chip counterpart of the simulation traffic generator, used in hardware NoC harnesses. It stamps each flit with its generation time and a per-destination sequence number, so a downstream checker can measure latency and detect loss or reordering.

## Interface
- SEED, 16'h0001: injection LFSR seed; destination LFSR seed is SEED ^ 16'hACE1; a seed of 0 is replaced by 1.
- COUNT_WIDTH, 32: width of all packet counters.
- TID, 0: this endpoint's ID, driven on tid.
- TDATA_WIDTH, 64: flit width; must be even.
- TDEST_WIDTH, 4: tdest width.
- TID_WIDTH, 4: tid width.
- NUM_ROUTERS, 16: number of destinations; 1..256.
- DISABLE_SELF, 0: 1 forbids tdest == TID.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  16  injection threshold; a flit is generated when r < load.
- num_packets  in  COUNT_WIDTH  flits to send per run; sampled on start.
- start  in  1  level; begins a run from IDLE.
- ticks  in  TDATA_WIDTH/2  free-running timestamp.
- done  out  1  run complete.
- sent_packets  out  [NUM_ROUTERS] x COUNT_WIDTH  handshakes per destination.
- total_sent_packets  out  COUNT_WIDTH  total handshakes.
- axis_out_tvalid/tready  out/in  1  AXIS handshake.
- axis_out_tdata  out  TDATA_WIDTH.
- axis_out_tlast  out  1  constant 1.
- axis_out_tid  out  TID_WIDTH.
- axis_out_tdest  out  TDEST_WIDTH.

## Operation
- **Reset values:** tvalid=0, tdata=0, tdest=0, tid=TID, done=0, all counters 0, state IDLE, both LFSRs at their seeds.
- **LFSRs:** 16-bit Galois, taps 16'hB400, shift right.
  - The injection LFSR r advances every cycle in RUN.
  - The destination LFSR d advances only when a flit is generated.
- **Destination:** dest = (d[7:0] * NUM_ROUTERS) >> 8. If DISABLE_SELF and dest == TID, dest = (TID+1) mod NUM_ROUTERS.
- **Output slot:** single registered slot. The slot is "free" when tvalid=0 or tvalid&tready.
- **Generation:** occurs in RUN when the slot is free, issued < num_packets, and r < load.
  - Payload: tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] = ticks; tdata[TDATA_WIDTH/2-1:0] = seq[dest] (low bits).
  - Side effects: issued++, seq[dest]++.
  - If the slot is busy, that cycle's draw is discarded.
- **Handshake:** payload is held stable while tvalid & !tready. On tvalid & tready, sent_packets[tdest]++ and total_sent_packets++.
- **FSM:**
  - IDLE: on start with num_packets != 0: clear counters, issued and seq, latch num_packets, go to RUN. On start with num_packets == 0: clear counters, go to DONE.
  - RUN: when issued == latched count, go to DRAIN.
  - DRAIN: on the handshake that leaves the slot empty, go to DONE.
  - DONE: done=1. On !start, go to IDLE; done drops and counters are retained.
- **Widths:** all counters wrap mod 2^COUNT_WIDTH. The seq field is truncated to TDATA_WIDTH/2.
- **Reset mid-operation:** all state returns to reset values at the reset edge, including an in-flight flit (tvalid drops). A new run after reset reproduces the identical flit sequence.

## Timing
- Start sampled high in IDLE at edge k → RUN at k+1. The first draw uses r from k+1; the earliest tvalid is at k+2.
- Draw to tvalid: 1 cycle. Back-to-back flits are possible every cycle under tready=1 and a passing draw.
- done is asserted the cycle after the final handshake. With num_packets=0, done rises 1 cycle after start is sampled.
- Counters update the cycle after their handshake.

## Structure
- Package noc_tg_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the LFSR_TAPS constant;
  - the lfsr16_next function.
- Sub-module lfsr16 (seed, enable, value), instantiated twice.

## Test plan
- **Full load:** load=16'hFFFF, num_packets=8, tready=1 → 8 handshakes within at most 10 cycles of RUN entry. Then total_sent_packets=8, done=1 the cycle after the last handshake, and the sent_packets entries sum to 8.
- **Zero load:** load=0, num_packets=100 → tvalid stays 0 for 1000 cycles and done stays 0.
- **Backpressure:** hold tready=0 for 5 cycles while tvalid=1 → tdata/tdest/tid stay stable and counters do not change. Release → exactly one increment.
- **Empty run:** num_packets=0 → done=1 one cycle after start, tvalid never asserts, and total_sent_packets=0.
- **Self-traffic disabled:** DISABLE_SELF=1, TID=3, load=16'hFFFF, num_packets=4096 → no flit has tdest=3 and sent_packets[3]=0. For each destination, the seq field runs 0,1,2,… with no gaps; every other sent_packets entry is ≥150.
- **Reset mid-run:** assert rst_n=0 after 10 handshakes → tvalid=0 and all counters 0 the next cycle. Rerun with the same inputs and ticks → the first 10 flits' tdest and seq match the first run.
